// File: rtl/reg_wb_sequencer.sv
// Register-file write-back sequencer: merges load and ALU results onto the single write port,
// tracks pending writes per register and runs the register zeroing sweep.
module reg_wb_sequencer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              busy1,
  output logic              busy2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              reg_w,
  output logic [ADDR_W-1:0] w_reg_addr,
  output logic [DATA_W-1:0] w_data
);

  localparam int unsigned NumRegs  = 1 << ADDR_W;
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam logic [CntW-1:0]   DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  typedef enum logic [1:0] {StIdle, StClrWait, StClear} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]     count_q, count_d;
  logic [NumRegs-1:0]  sb_q, sb_d;
  logic                reg_w_q, reg_w_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic                clr_busy_q, clr_busy_d;
  logic                fifo_empty, alu_keep, push, pop;

  assign fifo_empty = (count_q == '0);
  assign alu_ready  = (count_q < DepthCnt) && (state_q == StIdle);
  // Address-0 results are accepted but discarded here.
  assign alu_keep   = alu_valid && alu_ready && (alu_addr != '0);
  assign push       = alu_keep && (ld_valid || !fifo_empty);
  assign pop        = (state_q != StClear) && !ld_valid && !fifo_empty;

  assign busy1      = (chk_addr1 != '0) && sb_q[chk_addr1];
  assign busy2      = (chk_addr2 != '0) && sb_q[chk_addr2];
  assign clr_busy   = clr_busy_q;
  assign reg_w      = reg_w_q;
  assign w_reg_addr = w_addr_q;
  assign w_data     = w_data_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    reg_w_d  = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (state_q == StClear) begin
      reg_w_d  = 1'b1;
      w_addr_d = sweep_q;
      w_data_d = '0;
    end else if (ld_valid) begin
      if (ld_addr != '0) begin
        reg_w_d  = 1'b1;
        w_addr_d = ld_addr;
        w_data_d = ld_data;
      end
    end else if (!fifo_empty) begin
      reg_w_d  = 1'b1;
      w_addr_d = fifo_addr_q[rd_ptr_q];
      w_data_d = fifo_data_q[rd_ptr_q];
    end else if (alu_keep) begin
      reg_w_d  = 1'b1;
      w_addr_d = alu_addr;
      w_data_d = alu_data;
    end
  end

  always_comb begin
    sb_d = sb_q;
    if (reg_w_q) sb_d[w_addr_q] = 1'b0;
    // Applied after the clear so a same-cycle set wins.
    if (issue_valid && (issue_addr != '0) && (state_q == StIdle)) sb_d[issue_addr] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    clr_busy_d = clr_busy_q;
    unique case (state_q)
      StIdle: begin
        // clr_busy stays high for the cycle showing the last sweep write.
        if (clr_req && !clr_busy_q) begin
          state_d    = StClrWait;
          clr_busy_d = 1'b1;
        end else begin
          clr_busy_d = 1'b0;
        end
      end
      StClrWait: begin
        if (fifo_empty && (sb_q == '0) && !ld_valid) begin
          state_d = StClear;
          sweep_d = '0;
        end
      end
      StClear: begin
        sweep_d = sweep_q + ADDR_W'(1);
        if (sweep_q == LastAddr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sweep_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      sb_q       <= '0;
      reg_w_q    <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      count_q    <= count_d;
      sb_q       <= sb_d;
      reg_w_q    <= reg_w_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      clr_busy_q <= clr_busy_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Entry storage needs no reset: the count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= alu_addr;
      fifo_data_q[wr_ptr_q] <= alu_data;
    end
  end

endmodule

// File: tb/tb_reg_wb_sequencer.sv
// Self-checking bench for reg_wb_sequencer: directed scenarios plus a randomized run against a
// queue-based model of the write-back ordering and pending-write rules.
module tb_reg_wb_sequencer;

  logic        clk, rst_n;
  logic        alu_valid, alu_ready, ld_valid, issue_valid;
  logic [4:0]  alu_addr, ld_addr, issue_addr, chk_addr1, chk_addr2, w_reg_addr;
  logic [31:0] alu_data, ld_data, w_data;
  logic        busy1, busy2, clr_req, clr_busy, reg_w;
  int          n_checks, n_fail;

  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t aq[$];

  reg_wb_sequencer #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .busy1(busy1), .busy2(busy2),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .reg_w(reg_w), .w_reg_addr(w_reg_addr), .w_data(w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_addr = 0; alu_data = 0; ld_valid = 0; ld_addr = 0; ld_data = 0;
    issue_valid = 0; issue_addr = 0; chk_addr1 = 0; chk_addr2 = 0; clr_req = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    chk_addr1 = 5'd7; chk_addr2 = 5'd31;
    rst_n = 0;
    #3;
    n_checks++;
    if ({reg_w, w_reg_addr, w_data, clr_busy} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0", {reg_w, w_reg_addr, w_data, clr_busy});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    n_checks++;
    if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", alu_ready); end
    n_checks++;
    if ({busy1, busy2} !== 2'b00) begin n_fail++; $display("FAIL reset_busy got %b want 00", {busy1, busy2}); end
  endtask

  task automatic test_alu_stream();
    logic [4:0]  ta [3] = '{5'd3, 5'd4, 5'd5};
    logic [31:0] td [3] = '{32'h11, 32'h22, 32'h33};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_addr = ta[i]; alu_data = td[i];
      #1;
      n_checks++;
      if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_stream_ready[%0d] got %b want 1", i, alu_ready); end
      tick();
      n_checks++;
      if ({reg_w, w_reg_addr, w_data} !== {1'b1, ta[i], td[i]}) begin
        n_fail++;
        $display("FAIL alu_stream_write[%0d] got %h want %h", i, {reg_w, w_reg_addr, w_data}, {1'b1, ta[i], td[i]});
      end
    end
    // Address 0 is accepted but never written; port holds its last values.
    alu_valid = 1; alu_addr = 0; alu_data = 32'h99;
    #1;
    n_checks++;
    if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_zero_ready got %b want 1", alu_ready); end
    tick();
    alu_valid = 0;
    n_checks++;
    if ({reg_w, w_reg_addr, w_data} !== {1'b0, 5'd5, 32'h33}) begin
      n_fail++;
      $display("FAIL alu_zero_drop got %h want %h", {reg_w, w_reg_addr, w_data}, {1'b0, 5'd5, 32'h33});
    end
  endtask

  task automatic test_load_collision();
    logic [36:0] exp [3] = '{{5'd7, 32'hAA}, {5'd8, 32'hBB}, {5'd9, 32'hCC}};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ld_valid  = (i == 0); ld_addr = 5'd7; ld_data = 32'hAA;
      alu_valid = (i < 2);
      alu_addr  = (i == 0) ? 5'd8 : 5'd9;
      alu_data  = (i == 0) ? 32'hBB : 32'hCC;
      tick();
      n_checks++;
      if ({reg_w, w_reg_addr, w_data} !== {1'b1, exp[i]}) begin
        n_fail++;
        $display("FAIL collision_write[%0d] got %h want %h", i, {reg_w, w_reg_addr, w_data}, {1'b1, exp[i]});
      end
    end
    idle_inputs();
    tick();
    n_checks++;
    if (reg_w !== 1'b0) begin n_fail++; $display("FAIL collision_idle reg_w got %b want 0", reg_w); end
  endtask

  task automatic test_fifo_full();
    logic       exp_rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] exp_a   [6] = '{5'd10, 5'd11, 5'd12, 5'd20, 5'd21, 5'd22};
    logic [31:0] exp_d  [6] = '{32'h100, 32'h101, 32'h102, 32'hA0, 32'hA1, 32'hA2};
    int acc = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      ld_valid  = (c < 3); ld_addr = 5'(10 + c); ld_data = 32'h100 + 32'(c);
      alu_valid = (acc < 3); alu_addr = 5'(20 + acc); alu_data = 32'hA0 + 32'(acc);
      #1;
      n_checks++;
      if (alu_ready !== exp_rdy[c]) begin
        n_fail++; $display("FAIL fifo_full_ready[%0d] got %b want %b", c, alu_ready, exp_rdy[c]);
      end
      if (alu_valid && alu_ready) acc++;
      tick();
      n_checks++;
      if ({reg_w, w_reg_addr, w_data} !== {1'b1, exp_a[c], exp_d[c]}) begin
        n_fail++;
        $display("FAIL fifo_full_write[%0d] got %h want %h", c, {reg_w, w_reg_addr, w_data}, {1'b1, exp_a[c], exp_d[c]});
      end
    end
    idle_inputs();
    tick();
    n_checks++;
    if (acc !== 3) begin n_fail++; $display("FAIL fifo_full_accepts got %0d want 3", acc); end
    n_checks++;
    if (reg_w !== 1'b0) begin n_fail++; $display("FAIL fifo_full_idle reg_w got %b want 0", reg_w); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    chk_addr1 = 5'd6; chk_addr2 = 5'd9;
    issue_valid = 1; issue_addr = 5'd6;
    #1;
    n_checks++;
    if (busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_before_issue got %b want 0", busy1); end
    tick();
    issue_valid = 0;
    repeat (2) tick();
    n_checks++;
    if ({busy1, busy2} !== 2'b10) begin n_fail++; $display("FAIL sb_pending got %b want 10", {busy1, busy2}); end
    alu_valid = 1; alu_addr = 5'd6; alu_data = 32'h66;
    tick();
    alu_valid = 0;
    n_checks++;
    if ({reg_w, w_reg_addr, busy1} !== {1'b1, 5'd6, 1'b1}) begin
      n_fail++; $display("FAIL sb_write_cycle got %h want %h", {reg_w, w_reg_addr, busy1}, {1'b1, 5'd6, 1'b1});
    end
    tick();
    n_checks++;
    if (busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_cleared got %b want 0", busy1); end
    // Re-issue in the very cycle the old write to 9 is on the port: the set must survive.
    issue_valid = 1; issue_addr = 5'd9;
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_addr = 5'd9; alu_data = 32'h99;
    tick();
    alu_valid = 0;
    issue_valid = 1; issue_addr = 5'd9;
    tick();
    issue_valid = 0;
    n_checks++;
    if (busy2 !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins got %b want 1", busy2); end
    chk_addr1 = 0;
    issue_valid = 1; issue_addr = 0;
    tick();
    issue_valid = 0;
    n_checks++;
    if (busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_reg0 got %b want 0", busy1); end
  endtask

  task automatic test_clear();
    int nz = 0;
    do_reset();
    ld_valid = 1; ld_addr = 5'd12; ld_data = 32'h12;
    alu_valid = 1; alu_addr = 5'd13; alu_data = 32'h13;
    tick();
    ld_valid = 0; alu_valid = 0;
    n_checks++;
    if ({reg_w, w_reg_addr, w_data} !== {1'b1, 5'd12, 32'h12}) begin
      n_fail++; $display("FAIL clear_pre_load got %h want %h", {reg_w, w_reg_addr, w_data}, {1'b1, 5'd12, 32'h12});
    end
    clr_req = 1;
    tick();
    clr_req = 0;
    n_checks++;
    if ({reg_w, w_reg_addr, w_data, clr_busy} !== {1'b1, 5'd13, 32'h13, 1'b1}) begin
      n_fail++;
      $display("FAIL clear_fifo_first got %h want %h", {reg_w, w_reg_addr, w_data, clr_busy}, {1'b1, 5'd13, 32'h13, 1'b1});
    end
    alu_valid = 1; alu_addr = 5'd25; alu_data = 32'h25;
    for (int c = 0; c < 80 && nz < 32; c++) begin
      clr_req = (c == 10);
      #1;
      n_checks++;
      if ({alu_ready, clr_busy} !== 2'b01) begin
        n_fail++; $display("FAIL clear_ready_busy[%0d] got %b want 01", c, {alu_ready, clr_busy});
      end
      tick();
      if (reg_w === 1'b1) begin
        n_checks++;
        if ({w_reg_addr, w_data} !== {5'(nz), 32'h0}) begin
          n_fail++; $display("FAIL clear_write[%0d] got %h want %h", nz, {w_reg_addr, w_data}, {5'(nz), 32'h0});
        end
        nz++;
      end else if (nz > 0) begin
        n_checks++; n_fail++;
        $display("FAIL clear_gap after %0d writes got reg_w=%b want 1", nz, reg_w);
      end
    end
    alu_valid = 0; clr_req = 0;
    n_checks++;
    if (nz !== 32) begin n_fail++; $display("FAIL clear_count got %0d want 32", nz); end
    n_checks++;
    if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy_last got %b want 1", clr_busy); end
    tick();
    n_checks++;
    if ({reg_w, clr_busy} !== 2'b00) begin n_fail++; $display("FAIL clear_done got %b want 00", {reg_w, clr_busy}); end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (reg_w !== 1'b0) begin n_fail++; $display("FAIL clear_no_resweep[%0d] got %b want 0", c, reg_w); end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic found = 0;
    do_reset();
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      tick();
      if (reg_w === 1'b1 && w_reg_addr === 5'd10) found = 1;
    end
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL midclr_reach10 got %b want 1", found); end
    rst_n = 0;
    #1;
    n_checks++;
    if ({reg_w, w_reg_addr, w_data, clr_busy} !== 39'd0) begin
      n_fail++; $display("FAIL midclr_async got %h want 0", {reg_w, w_reg_addr, w_data, clr_busy});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      n_checks++;
      if ({reg_w, clr_busy, alu_ready} !== 3'b001) begin
        n_fail++; $display("FAIL midclr_after[%0d] got %b want 001", c, {reg_w, clr_busy, alu_ready});
      end
    end
  endtask

  task automatic test_random();
    bit          pend [32];
    logic        ev = 0, nv, exp_rdy;
    logic [4:0]  ea = 0, na, ha = 0;
    logic [31:0] ed = 0, nd, hd = 0;
    wr_t         w;
    do_reset();
    aq.delete();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++;
      if (ev) begin
        if ({reg_w, w_reg_addr, w_data} !== {1'b1, ea, ed}) begin
          n_fail++; $display("FAIL rand_write[%0d] got %h want %h", cyc, {reg_w, w_reg_addr, w_data}, {1'b1, ea, ed});
        end
        ha = ea; hd = ed;
      end else if ({reg_w, w_reg_addr, w_data} !== {1'b0, ha, hd}) begin
        n_fail++; $display("FAIL rand_hold[%0d] got %h want %h", cyc, {reg_w, w_reg_addr, w_data}, {1'b0, ha, hd});
      end
      alu_valid   = ($urandom_range(0, 99) < 60);
      alu_addr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_data    = $urandom;
      ld_valid    = ($urandom_range(0, 99) < 35);
      ld_addr     = 5'($urandom_range(1, 31));
      ld_data     = $urandom;
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_addr  = 5'($urandom_range(0, 31));
      chk_addr1   = 5'($urandom_range(0, 31));
      chk_addr2   = 5'($urandom_range(0, 31));
      #1;
      exp_rdy = (aq.size() < 2);
      n_checks++;
      if (alu_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rand_ready[%0d] got %b want %b", cyc, alu_ready, exp_rdy);
      end
      n_checks++;
      if ({busy1, busy2} !== {(chk_addr1 != 0) && pend[chk_addr1], (chk_addr2 != 0) && pend[chk_addr2]}) begin
        n_fail++;
        $display("FAIL rand_busy[%0d] got %b want %b", cyc, {busy1, busy2},
                 {(chk_addr1 != 0) && pend[chk_addr1], (chk_addr2 != 0) && pend[chk_addr2]});
      end
      // Loads own the port; otherwise the oldest ALU result goes out.
      if (alu_valid && exp_rdy && alu_addr != 0) aq.push_back({alu_addr, alu_data});
      nv = 0; na = 0; nd = 0;
      if (ld_valid) begin
        nv = 1; na = ld_addr; nd = ld_data;
      end else if (aq.size() > 0) begin
        w = aq.pop_front();
        nv = 1; na = w.a; nd = w.d;
      end
      if (ev) pend[ea] = 0;
      if (issue_valid && issue_addr != 0) pend[issue_addr] = 1;
      ev = nv; ea = na; ed = nd;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    rst_n = 1;
    test_reset();
    test_alu_stream();
    test_load_collision();
    test_fifo_full();
    test_scoreboard();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_wb_sequencer.md
Name: reg_wb_sequencer

Overview:
- Sole writer of the 32x32 register file. Drives its single write port (reg_w, w_reg_addr, w_data).
- Merges ALU results and load results onto that port, using a small ordering FIFO for ALU results.
- Keeps a per-register pending-write scoreboard that decode checks before reading operands.
- Runs a 32-cycle zeroing sweep on request. This replaces a bulk clear of the register file.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (2^ADDR_W registers)
FIFO_DEPTH, 2, ALU result buffer entries (power of two, >=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result present
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU result accepted this cycle when alu_valid&alu_ready
ld_valid  in  1  load result present; never stalled
ld_addr  in  ADDR_W  load destination register
ld_data  in  DATA_W  load data
issue_valid  in  1  decode issued instruction writing issue_addr
issue_addr  in  ADDR_W  destination to mark pending
chk_addr1  in  ADDR_W  operand 1 register to check
chk_addr2  in  ADDR_W  operand 2 register to check
busy1  out  1  chk_addr1 has a pending write
busy2  out  1  chk_addr2 has a pending write
clr_req  in  1  one-cycle pulse: zero all registers
clr_busy  out  1  clear pending or in progress
reg_w  out  1  register file write enable
w_reg_addr  out  ADDR_W  register file write address
w_data  out  DATA_W  register file write data

Behaviour:
- Reset (rst_n=0, async):
  - reg_w=0, w_reg_addr=0, w_data=0, clr_busy=0.
  - FIFO empty; scoreboard all 0; state IDLE.
  - alu_ready=1 once reset is released.
- Write port outputs are registered. A result accepted in cycle N appears on reg_w/w_reg_addr/w_data in cycle N+1 at the earliest.
- Address 0 writes are dropped: never emitted, never enter the FIFO, but are still accepted.
- Port arbitration each cycle, highest priority first:
  - CLEAR sweep.
  - ld_valid.
  - FIFO head.
  - Direct ALU result; allowed only if the FIFO is empty and no load is present.
- An ALU result that cannot go direct is pushed to the FIFO, so ALU order is preserved.
- alu_ready = (FIFO count < FIFO_DEPTH) && state==IDLE.
- A pop and a push in the same cycle are both allowed, with count unchanged. The FIFO never overflows.
- Scoreboard (one busy bit per register):
  - Set on issue_valid when issue_addr!=0 and state==IDLE.
  - Cleared for w_reg_addr in the cycle reg_w is driven high.
  - Set and clear to the same address in one cycle: set wins.
  - busyK = bit[chk_addrK], combinational; register 0 always reads 0.
  - Decode guarantees at most one outstanding write per register.
- Clear FSM:
  - IDLE: clr_req -> CLR_WAIT.
  - CLR_WAIT:
    - clr_busy=1 and alu_ready=0; issue_valid is ignored.
    - Loads and FIFO entries keep draining.
    - Leaves for CLEAR when the FIFO is empty, the scoreboard is all zero and no ld_valid is present.
  - CLEAR:
    - 5-bit counter runs 0..31; each cycle emits reg_w=1, w_reg_addr=counter, w_data=0. Register 0 is included here only.
    - After counter=31 -> IDLE, with clr_busy low in the following cycle.
    - A ld_valid during CLEAR is a protocol violation; it is dropped.
  - clr_req while clr_busy=1: ignored.
- Reset mid-sweep: sweep is aborted, state returns to IDLE, outputs go to their reset values.
- Idle port: reg_w=0; w_reg_addr and w_data hold their last values.

Test Plan:
- ALU stream only:
  - Stimulus: alu (3,0x11), (4,0x22), (5,0x33) in consecutive cycles.
  - Required: reg_w on cycles 1–3 with addresses 3,4,5 and data as given; FIFO stays empty.
- Load collision:
  - Stimulus: same cycle ld (7,0xAA) and alu (8,0xBB); next cycle alu (9,0xCC).
  - Required: emits 7/0xAA, then 8/0xBB, then 9/0xCC.
- FIFO full:
  - Stimulus: ld_valid held 3 cycles while alu_valid is held.
  - Required: alu_ready drops after 2 accepts; no result is lost; ALU results drain in order after the loads.
- Scoreboard:
  - Stimulus: issue 6, then chk_addr1=6.
  - Required: busy1=1 until the cycle w_reg_addr=6 with reg_w=1; busy1=0 after that.
  - Stimulus: issue 0. Required: busy stays 0.
- Clear:
  - Stimulus: clr_req while the FIFO holds 1 entry.
  - Required: entry written first, then exactly 32 zero writes to addresses 0..31; clr_busy high throughout; alu_ready=0.
- Reset mid-CLEAR:
  - Stimulus: rst_n low at counter=10.
  - Required: outputs go to 0 immediately; state IDLE; no further zero writes after rst_n returns high.
